// File: rtl/corefifo_wr_ptr_gen_if.sv
// Write-side handshake bundle for corefifo_wr_ptr_gen.
// The master drives the write request and synchronized read pointer; the slave returns the pointers and flags.
interface corefifo_wr_ptr_gen_if #(
  parameter int ADDRWIDTH = 3
);
  logic                 wr_en;
  logic [ADDRWIDTH:0]   rd_ptr_gray_sync;
  logic [ADDRWIDTH-1:0] wr_addr;
  logic [ADDRWIDTH:0]   wr_ptr_bin;
  logic [ADDRWIDTH:0]   wr_ptr_gray;
  logic                 full;
  logic                 wr_ack;
  logic                 overflow;
  logic                 almost_full;

  modport master (
    output wr_en, rd_ptr_gray_sync,
    input  wr_addr, wr_ptr_bin, wr_ptr_gray, full, wr_ack, overflow, almost_full
  );

  modport slave (
    input  wr_en, rd_ptr_gray_sync,
    output wr_addr, wr_ptr_bin, wr_ptr_gray, full, wr_ack, overflow, almost_full
  );
endinterface

// File: rtl/corefifo_wr_ptr_gen.sv
// COREFIFO write-side pointer generator: binary/Gray write pointer, full, ack and overflow.
// Define CFIFO_AFULL_EN to build the almost-full level comparator; otherwise almost_full is tied low.
module corefifo_wr_ptr_gen #(
  parameter int ADDRWIDTH    = 3,
  parameter int AFULL_THRESH = 6
) (
  input logic                      clk,
  input logic                      rst,
  corefifo_wr_ptr_gen_if.slave     wif
);
  localparam int PW = ADDRWIDTH + 1;

  logic [PW-1:0] bin_q;
  logic [PW-1:0] gray_q;
  logic          full_q;
  logic          ack_q;
  logic          ovf_q;

  logic          accept;
  logic [PW-1:0] bin_next;
  logic [PW-1:0] gray_next;
  logic [PW-1:0] full_match;

  // Full when the next write pointer has lapped the reader: top two Gray bits inverted, rest equal.
  always_comb begin
    accept     = wif.wr_en & ~full_q;
    bin_next   = bin_q + PW'(accept);
    gray_next  = bin_next ^ (bin_next >> 1);
    full_match = {~wif.rd_ptr_gray_sync[PW-1:PW-2], wif.rd_ptr_gray_sync[PW-3:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q  <= '0;
      gray_q <= '0;
      full_q <= 1'b0;
      ack_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      bin_q  <= bin_next;
      gray_q <= gray_next;
      full_q <= (gray_next == full_match);
      ack_q  <= accept;
      ovf_q  <= wif.wr_en & full_q;
    end
  end

`ifdef CFIFO_AFULL_EN
  logic [PW-1:0] rd_bin;
  logic [PW-1:0] level;
  logic          afull_q;

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rd_bin = '0;
    for (int i = 0; i < PW; i++) begin
      rd_bin[i] = ^(wif.rd_ptr_gray_sync >> i);
    end
    level = bin_next - rd_bin;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      afull_q <= 1'b0;
    end else begin
      afull_q <= (level >= PW'(AFULL_THRESH));
    end
  end

  assign wif.almost_full = afull_q;
`else
  assign wif.almost_full = 1'b0;
`endif

  assign wif.wr_addr     = bin_q[ADDRWIDTH-1:0];
  assign wif.wr_ptr_bin  = bin_q;
  assign wif.wr_ptr_gray = gray_q;
  assign wif.full        = full_q;
  assign wif.wr_ack      = ack_q;
  assign wif.overflow    = ovf_q;
endmodule

// File: tb/tb_corefifo_wr_ptr_gen.sv
// Directed-vector bench for corefifo_wr_ptr_gen with ADDRWIDTH=3, AFULL_THRESH=6.
module tb_corefifo_wr_ptr_gen;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  corefifo_wr_ptr_gen_if #(.ADDRWIDTH(AW)) wif ();

  corefifo_wr_ptr_gen #(.ADDRWIDTH(AW), .AFULL_THRESH(6)) dut (
    .clk (clk),
    .rst (rst),
    .wif (wif.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       wr;
    logic [3:0] rd;
    logic [3:0] bin;
    logic [3:0] gray;
    logic       full;
    logic       ack;
    logic       ovf;
    logic       af;   // value expected when the almost-full feature is built
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input logic r, input logic w, input logic [3:0] rd);
    rst = r;
    wif.wr_en = w;
    wif.rd_ptr_gray_sync = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [3:0] bin, input logic [3:0] gray,
                           input logic full, input logic ack, input logic ovf, input logic af);
    logic af_exp;
`ifdef CFIFO_AFULL_EN
    af_exp = af;
`else
    af_exp = 1'b0;
`endif
    check({tag, ".bin"},  32'(wif.wr_ptr_bin),  32'(bin));
    check({tag, ".gray"}, 32'(wif.wr_ptr_gray), 32'(gray));
    check({tag, ".addr"}, 32'(wif.wr_addr),     32'(bin[2:0]));
    check({tag, ".full"}, 32'(wif.full),        32'(full));
    check({tag, ".ack"},  32'(wif.wr_ack),      32'(ack));
    check({tag, ".ovf"},  32'(wif.overflow),    32'(ovf));
    check({tag, ".afull"}, 32'(wif.almost_full), 32'(af_exp));
  endtask

  function automatic logic [3:0] to_gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  initial begin
    logic [3:0] b;
    wif.wr_en = 1'b0;
    wif.rd_ptr_gray_sync = '0;

    //         rst   wr    rd     bin    gray   full  ack   ovf   af
    vecs[0]  = '{1'b1, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 4'h0, 4'h1, 4'h1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 4'h0, 4'h2, 4'h3, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 4'h0, 4'h3, 4'h2, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 4'h0, 4'h4, 4'h6, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 4'h0, 4'h5, 4'h7, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 4'h0, 4'h6, 4'h5, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 4'h0, 4'h7, 4'h4, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 4'h0, 4'h8, 4'hC, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 4'h0, 4'h8, 4'hC, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 4'h0, 4'h8, 4'hC, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 4'h1, 4'h8, 4'hC, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 4'h1, 4'h9, 4'hD, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 4'h1, 4'h9, 4'hD, 1'b1, 1'b0, 1'b1, 1'b1};

    for (int i = 0; i < 14; i++) begin
      apply(vecs[i].rst, vecs[i].wr, vecs[i].rd);
      check_all($sformatf("vec%0d", i), vecs[i].bin, vecs[i].gray, vecs[i].full,
                vecs[i].ack, vecs[i].ovf, vecs[i].af);
    end

    // Wrap: reader trails one entry behind, so the FIFO never fills.
    apply(1'b1, 1'b0, 4'h0);
    check_all("wrap_rst", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    b = 4'h0;
    for (int k = 0; k < 16; k++) begin
      apply(1'b0, 1'b1, to_gray(b - 4'h1));
      b = b + 4'h1;
      check_all($sformatf("wrap%0d", k), b, to_gray(b), 1'b0, 1'b1, 1'b0, 1'b0);
    end
    check("wrap_end_bin", 32'(wif.wr_ptr_bin), 32'h0);
    check("wrap_end_gray", 32'(wif.wr_ptr_gray), 32'h0);

    // Reset in the middle of a write burst.
    apply(1'b1, 1'b0, 4'h0);
    for (int k = 0; k < 5; k++) apply(1'b0, 1'b1, 4'h0);
    check_all("pre_rst", 4'h5, 4'h7, 1'b0, 1'b1, 1'b0, 1'b0);
    apply(1'b1, 1'b1, 4'h0);
    check_all("mid_rst", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 1'b1, 4'h0);
    check_all("post_rst", 4'h1, 4'h1, 1'b0, 1'b1, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 4'h0);
    check_all("post_idle", 4'h1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/corefifo_wr_ptr_gen.md
Name: corefifo_wr_ptr_gen

Overview:
- Write-side pointer generator for the dual-clock COREFIFO.
- Keeps the binary write pointer, encodes it to Gray for clock-domain crossing, and drives the RAM write address.
- Computes full, ack and overflow against the read pointer. The read pointer arrives as Gray code, already double-synchronized into the write clock domain.
- This is the encoder counterpart of the read-side Gray-to-binary converter. It sits in the write-clock domain next to the write-enable qualifier.

Parameters:
- ADDRWIDTH, 3, RAM address width. Pointers are ADDRWIDTH+1 bits; the MSB is the wrap bit. Minimum legal value is 2.
- AFULL_THRESH, 6, almost-full assertion level in entries. Used only when CFIFO_AFULL_EN is defined. Legal range 1..2^ADDRWIDTH.

Ports:
- clk, input, 1, write-domain clock.
- rst, input, 1, synchronous active-high reset.
- wr_en, input, 1, write request.
- rd_ptr_gray_sync, input, ADDRWIDTH+1, read pointer in Gray code, synchronized to clk.
- wr_addr, output, ADDRWIDTH, RAM write address; equals wr_ptr_bin[ADDRWIDTH-1:0].
- wr_ptr_bin, output, ADDRWIDTH+1, registered binary write pointer.
- wr_ptr_gray, output, ADDRWIDTH+1, registered Gray write pointer, sent to the read-domain synchronizer.
- full, output, 1, registered FIFO-full flag.
- wr_ack, output, 1, one-cycle pulse: the previous cycle's write was accepted.
- overflow, output, 1, one-cycle pulse: the previous cycle's write was rejected because full was set.
- almost_full, output, 1, registered almost-full flag; see Optional Feature.

Behaviour:
- Reset: sync on rising clk while rst=1. wr_ptr_bin=0, wr_ptr_gray=0, full=0, wr_ack=0, overflow=0, almost_full=0. Reset has priority over everything. Reset mid-operation discards the pointer and flags on the next edge, with no partial update.
- accept = wr_en & ~full, using the registered full.
- Next binary pointer: bin_next = wr_ptr_bin + accept, modulo 2^(ADDRWIDTH+1). Wrap from all-ones to 0 is silent.
- Next Gray pointer: gray_next = bin_next ^ (bin_next >> 1). It is registered together with wr_ptr_bin, so the Gray output changes by exactly one bit per accepted write. It never glitches, because it is a register output.
- Full: full <= (gray_next == {~rd_ptr_gray_sync[ADDRWIDTH:ADDRWIDTH-1], rd_ptr_gray_sync[ADDRWIDTH-2:0]}).
- Full is re-evaluated every cycle, including cycles with no write. It therefore deasserts one clk after the synchronized read pointer advances.
- A write accepted on the cycle that fills the FIFO produces full=1 on the same edge as its wr_ack.
- wr_ack <= accept.
- overflow <= wr_en & full. The pointer does not move on an overflowing request.
- Latency: wr_addr and the pointers update 1 clk after an accepted wr_en. The RAM write uses wr_addr sampled in the accept cycle, i.e. the pre-increment value.
- Simultaneous write and read-pointer change: both are reflected in the same full computation, with no priority conflict. A read that frees space in the same cycle as a write rejected by full does not retroactively accept that write.
- rd_ptr_gray_sync is treated as stable per clk. Its multi-bit skew is handled upstream by the Gray single-bit-change property.

Optional Feature:
- Macro: CFIFO_AFULL_EN.
- Defined:
  - rd_ptr_gray_sync is converted internally to binary (rd_bin[MSB]=g[MSB]; rd_bin[i]=rd_bin[i+1]^g[i]).
  - level = (bin_next - rd_bin) mod 2^(ADDRWIDTH+1).
  - almost_full <= (level >= AFULL_THRESH).
  - Registered, same timing as full; cleared by reset.
- Undefined: almost_full is driven constant 0, and no conversion or subtractor logic is generated.

Test Plan:
- Reset, then hold rd_ptr_gray_sync=0 with ADDRWIDTH=3 and issue 8 back-to-back writes.
  - wr_ptr_gray sequence 1,3,2,6,7,5,4,C.
  - wr_addr 0..7 at accept.
  - full=1 on the edge of the 8th wr_ack.
- With full=1, assert wr_en for 2 cycles -> overflow pulses twice, wr_ack=0, pointer holds at bin 8, gray C.
- From full, set rd_ptr_gray_sync=1 -> full=0 one clk later; the next write is accepted and full re-asserts, with gray moving C to D.
- Run 16 writes with the reader tracking (rd = wr-1 in Gray) -> bin wraps F to 0 and gray 8 to 0, with no false full.
- Assert rst after 5 writes while wr_en=1 -> next edge: all outputs 0. The first write after reset yields gray 1.
- CFIFO_AFULL_EN defined, AFULL_THRESH=6, rd=0 -> almost_full rises with the 6th wr_ack and full with the 8th. Macro undefined -> almost_full stays 0 throughout.
